// File: rtl/shift_unit.sv
// Iterative shift/rotate unit: latches operand, op and amount on start, moves
// one bit position per clock, then pulses done with the result on data_out.
module shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] amount,
  input  logic [WIDTH-1:0]   data_in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   data_out,
  output logic [1:0]         dbg_state_o
);

  // Handshake: start is a request sampled only in IDLE (ignored while busy);
  // done is a one-cycle pulse with data_out valid, held until the next accept.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q,  data_d;
  logic [2:0]         op_q,    op_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0]   step_val;

  // Single-bit step of the latched operation; unknown ops leave data untouched.
  always_comb begin
    step_val = data_q;
    case (op_q)
      OP_SLL:  step_val = {data_q[WIDTH-2:0], 1'b0};
      OP_SRL:  step_val = {1'b0, data_q[WIDTH-1:1]};
      OP_SRA:  step_val = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
      OP_ROL:  step_val = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
      OP_ROR:  step_val = {data_q[0], data_q[WIDTH-1:1]};
      default: step_val = data_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = data_in;
          op_d    = op;
          count_d = amount;
          state_d = (amount != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        data_d  = step_val;
        count_d = count_q - 1'b1;
        if (count_q == SHAMT_W'(1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      op_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      count_q <= count_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign data_out    = data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit: vector table plus hand-written sequences for
// reset, busy-time start/input changes, back-to-back requests and mid-run reset.
module tb_shift_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [4:0]  amount;
  logic [31:0] data_in;
  logic        busy;
  logic        done;
  logic [31:0] data_out;
  logic [1:0]  dbg_state_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .amount(amount),
    .data_in(data_in), .busy(busy), .done(done), .data_out(data_out),
    .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  amt;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Issue one request from IDLE, wait for done, check latency, busy, result and
  // the single-cycle pulse; leaves the bench in the IDLE cycle after done.
  task automatic run_op(input string name, input logic [2:0] o, input logic [4:0] a,
                        input logic [31:0] d, input logic [31:0] e);
    int c;
    logic busy_ok;
    logic [31:0] expv;
    exp_q.push_back(e);
    start = 1'b1; op = o; amount = a; data_in = d;
    tick();
    start = 1'b0; op = 3'b000; amount = 5'd0; data_in = 32'h0;
    c = 0;
    busy_ok = 1'b1;
    while (!done && c < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      c++;
    end
    chk({name, "_latency"}, 32'(c), 32'(a));
    chk({name, "_busy"}, {31'b0, busy_ok & busy}, 32'd1);
    expv = exp_q.pop_front();
    chk({name, "_data"}, data_out, expv);
    tick();
    chk({name, "_done_pulse"}, {30'b0, done, busy}, 32'd0);
    chk({name, "_hold"}, data_out, expv);
  endtask

  initial begin
    vecs[0]  = '{3'b001, 5'd4,  32'h0000_0001, 32'h0000_0010};
    vecs[1]  = '{3'b011, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF};
    vecs[2]  = '{3'b010, 5'd31, 32'h8000_0000, 32'h0000_0001};
    vecs[3]  = '{3'b101, 5'd1,  32'h0000_0001, 32'h8000_0000};
    vecs[4]  = '{3'b100, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[5]  = '{3'b111, 5'd3,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[6]  = '{3'b100, 5'd4,  32'h8000_0001, 32'h0000_0018};
    vecs[7]  = '{3'b101, 5'd8,  32'h0000_00F0, 32'hF000_0000};
    vecs[8]  = '{3'b011, 5'd16, 32'h7FFF_0000, 32'h0000_7FFF};
    vecs[9]  = '{3'b001, 5'd31, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[10] = '{3'b000, 5'd0,  32'h1234_5678, 32'h1234_5678};
    vecs[11] = '{3'b011, 5'd4,  32'hF000_0000, 32'hFF00_0000};
    vecs[12] = '{3'b010, 5'd4,  32'hF000_0000, 32'h0F00_0000};

    // Reset held two cycles with start asserted.
    reset = 1'b0; start = 1'b1; op = 3'b001; amount = 5'd3; data_in = 32'hA5A5_A5A5;
    tick();
    tick();
    chk("reset_data", data_out, 32'h0);
    chk("reset_flags", {30'b0, busy, done}, 32'd0);
    chk("reset_state", {30'b0, dbg_state_o}, 32'd0);
    start = 1'b0;
    reset = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].amt, vecs[i].din, vecs[i].exp);
    end

    // start held and inputs toggled while busy: result unaffected, no extra done.
    begin
      int c;
      start = 1'b1; op = 3'b001; amount = 5'd6; data_in = 32'h0000_0003;
      tick();
      c = 0;
      while (!done && c < 100) begin
        op = 3'($urandom_range(0, 7));
        amount = 5'($urandom_range(0, 31));
        data_in = $urandom;
        tick();
        c++;
      end
      chk("busy_start_latency", 32'(c), 32'd6);
      chk("busy_start_data", data_out, 32'h0000_00C0);
      data_in = 32'h5555_5555; amount = 5'd2; op = 3'b010;
      tick();
      chk("after_done_flags", {30'b0, busy, done}, 32'd0);
      chk("after_done_hold", data_out, 32'h0000_00C0);
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tick();
        chk("idle_quiet", {30'b0, busy, done}, 32'd0);
      end
    end

    // Back-to-back requests, each issued in the first IDLE cycle after done.
    run_op("b2b_a", 3'b001, 5'd2, 32'h0000_0001, 32'h0000_0004);
    run_op("b2b_b", 3'b101, 5'd4, 32'h0000_000F, 32'hF000_0000);

    // Reset in the middle of a long shift aborts without a done pulse.
    begin
      logic saw_done;
      start = 1'b1; op = 3'b001; amount = 5'd20; data_in = 32'h0000_0001;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      chk("mid_shift_data", data_out, 32'h0000_0020);
      chk("mid_shift_state", {30'b0, dbg_state_o}, 32'd1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("abort_data", data_out, 32'h0);
      chk("abort_state", {29'b0, dbg_state_o, busy}, 32'd0);
      saw_done = 1'b0;
      for (int k = 0; k < 20; k++) begin
        if (done) saw_done = 1'b1;
        tick();
      end
      chk("abort_no_done", {31'b0, saw_done}, 32'd0);
    end
    run_op("after_abort", 3'b011, 5'd8, 32'h8000_0000, 32'hFF80_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
